// File: rtl/sram_resp_model.sv
// Clocked responder for asynchronous-SRAM-style pins (ce_n/oe_n/we_n/be_n,
// 20-bit word address, 32-bit bidirectional data). It serves reads after a
// configurable latency and byte-enabled writes from an internal word array.
// It flags the illegal read+write control combination and counts completed
// transactions. It stands in for BaseRAM/ExtRAM in loopback and simulation.
module sram_resp_model #(
  parameter int ADDR_W = 10,
  parameter int RD_LAT = 1
) (
  input  logic        clk,
  input  logic        resetn,
  inout  wire  [31:0] ram_data,
  input  logic [19:0] ram_addr,
  input  logic [3:0]  ram_be_n,
  input  logic        ram_ce_n,
  input  logic        ram_oe_n,
  input  logic        ram_we_n,
  output logic        err_conflict,
  output logic [15:0] rd_cnt,
  output logic [15:0] wr_cnt
);

  localparam int DATA_W = 32;
  localparam int DEPTH  = 1 << ADDR_W;
  // Latency counter reload. The request edge itself is the first of the
  // RD_LAT cycles, so the counter starts at RD_LAT-1.
  localparam logic [2:0] LAT_RELOAD = 3'(RD_LAT - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RD_WAIT   = 2'd1,
    RD_DRIVE  = 2'd2,
    WR_ACTIVE = 2'd3
  } state_t;

  state_t              state;
  logic [2:0]          lat_cnt;
  logic [ADDR_W-1:0]   cap_addr;
  logic [3:0]          cap_be_n;
  logic [DATA_W-1:0]   cap_data;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic                rd_req;
  logic                wr_req;
  logic                conflict;
  logic                addr_change;
  logic                commit;
  logic                drive;
  logic [ADDR_W-1:0]   addr_word;

  // Saturating 16-bit increment for the transaction counters.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Only the low ADDR_W address bits select a word; the upper bits alias.
  assign addr_word = ram_addr[ADDR_W-1:0];

  generate
    if (ADDR_W < 20) begin : g_alias
      logic unused_addr_hi;
      assign unused_addr_hi = ^ram_addr[19:ADDR_W];
    end
  endgenerate

  // A write request covers the conflict case too: a conflict is a write
  // that also has oe_n low, and the bus must never be driven for it.
  assign rd_req      = !ram_ce_n && !ram_oe_n && ram_we_n;
  assign wr_req      = !ram_ce_n && !ram_we_n;
  assign conflict    = !ram_ce_n && !ram_oe_n && !ram_we_n;
  assign addr_change = (addr_word != cap_addr);
  assign commit      = (state == WR_ACTIVE) && !wr_req;
  assign drive       = (state == RD_DRIVE);

  // The bus carries the addressed word only while the FSM sits in RD_DRIVE.
  // Otherwise it is released.
  assign ram_data = drive ? mem[cap_addr] : {DATA_W{1'bz}};

  // Control FSM, latency counter, sticky conflict flag and saturating counters.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state        <= IDLE;
      lat_cnt      <= 3'd0;
      err_conflict <= 1'b0;
      rd_cnt       <= 16'd0;
      wr_cnt       <= 16'd0;
    end else begin
      if (conflict) begin
        err_conflict <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (wr_req) begin
            state <= WR_ACTIVE;
          end else if (rd_req) begin
            lat_cnt <= LAT_RELOAD;
            state   <= (RD_LAT == 1) ? RD_DRIVE : RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (wr_req) begin
            // Abandon the read with no count. The write wins.
            state <= WR_ACTIVE;
          end else if (!rd_req) begin
            state <= IDLE;
          end else if (addr_change) begin
            lat_cnt <= LAT_RELOAD;
          end else if (lat_cnt <= 3'd1) begin
            lat_cnt <= 3'd0;
            state   <= RD_DRIVE;
          end else begin
            lat_cnt <= lat_cnt - 3'd1;
          end
        end
        RD_DRIVE: begin
          if (wr_req) begin
            state <= WR_ACTIVE;
          end else if (!rd_req) begin
            state  <= IDLE;
            rd_cnt <= sat_inc(rd_cnt);
          end else if (addr_change && (RD_LAT != 1)) begin
            // New address: release the bus and restart the full latency.
            lat_cnt <= LAT_RELOAD;
            state   <= RD_WAIT;
          end
        end
        WR_ACTIVE: begin
          if (!wr_req) begin
            state  <= IDLE;
            wr_cnt <= sat_inc(wr_cnt);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Request capture. While a write is held, the last sampled address, enables
  // and data win. A read recaptures its address every cycle it is held.
  always_ff @(posedge clk) begin
    if (wr_req) begin
      cap_addr <= addr_word;
      cap_be_n <= ram_be_n;
      cap_data <= ram_data;
    end else if (rd_req && (state != WR_ACTIVE)) begin
      cap_addr <= addr_word;
    end
  end

  // Byte-lane commit on the first cycle after the write request drops.
  // A reset edge discards the pending write.
  always_ff @(posedge clk) begin
    if (resetn && commit) begin
      for (int i = 0; i < 4; i++) begin
        if (!cap_be_n[i]) begin
          mem[cap_addr][8*i +: 8] <= cap_data[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_sram_resp_model.sv
// Bench for sram_resp_model. Two instances (read latency 1 and 3) share one
// control stimulus. Each instance has its own pulled-up data bus, so a
// released bus reads as all ones.
module tb_sram_resp_model;

  localparam int LAT_A = 1;
  localparam int LAT_B = 3;

  logic        clk = 1'b0;
  logic        resetn;
  logic [19:0] addr;
  logic [3:0]  be_n;
  logic        ce_n, oe_n, we_n;
  logic        tb_drive;
  logic [31:0] tb_data;

  tri1  [31:0] bus1;
  tri1  [31:0] bus3;
  logic        err1, err3;
  logic [15:0] rdc1, rdc3, wrc1, wrc3;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state.
  logic [31:0] ref_mem [int unsigned];
  int unsigned known[$];
  logic [15:0] rd_exp1, rd_exp3, wr_exp;
  logic        err_exp;

  assign bus1 = tb_drive ? tb_data : 32'hzzzz_zzzz;
  assign bus3 = tb_drive ? tb_data : 32'hzzzz_zzzz;

  always #5 clk = ~clk;

  sram_resp_model #(.ADDR_W(10), .RD_LAT(LAT_A)) dut1 (
    .clk(clk), .resetn(resetn), .ram_data(bus1), .ram_addr(addr),
    .ram_be_n(be_n), .ram_ce_n(ce_n), .ram_oe_n(oe_n), .ram_we_n(we_n),
    .err_conflict(err1), .rd_cnt(rdc1), .wr_cnt(wrc1)
  );

  sram_resp_model #(.ADDR_W(10), .RD_LAT(LAT_B)) dut3 (
    .clk(clk), .resetn(resetn), .ram_data(bus3), .ram_addr(addr),
    .ram_be_n(be_n), .ram_ce_n(ce_n), .ram_oe_n(oe_n), .ram_we_n(we_n),
    .err_conflict(err3), .rd_cnt(rdc3), .wr_cnt(wrc3)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  function automatic int unsigned widx(input logic [19:0] a);
    return {22'd0, a[9:0]};
  endfunction

  function automatic logic [19:0] mk_addr(input int unsigned w);
    return {10'($urandom), 10'(w)};
  endfunction

  function automatic logic [15:0] sat16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Data on the bus "age" cycles after a request edge: the word once the
  // latency has elapsed, otherwise the pulled-up idle value.
  function automatic logic [31:0] exp_bus(input int lat, input int age, input logic [19:0] a);
    return (age >= lat) ? ref_mem[widx(a)] : 32'hFFFF_FFFF;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic check_status();
    check("err_conflict_l1", {31'd0, err1}, {31'd0, err_exp});
    check("err_conflict_l3", {31'd0, err3}, {31'd0, err_exp});
    check("rd_cnt_l1", {16'd0, rdc1}, {16'd0, rd_exp1});
    check("rd_cnt_l3", {16'd0, rdc3}, {16'd0, rd_exp3});
    check("wr_cnt_l1", {16'd0, wrc1}, {16'd0, wr_exp});
    check("wr_cnt_l3", {16'd0, wrc3}, {16'd0, wr_exp});
  endtask

  task automatic idle_inputs();
    ce_n = 1'b1; oe_n = 1'b1; we_n = 1'b1; tb_drive = 1'b0;
  endtask

  task automatic check_bus(input int e, input logic [19:0] a1, input int n1, input logic [19:0] a2);
    int seg;
    logic [19:0] sa;
    seg = (e < n1) ? 0 : n1;
    sa  = (e < n1) ? a1 : a2;
    check("rd_bus_l1", bus1, exp_bus(LAT_A, e - seg + 1, sa));
    check("rd_bus_l3", bus3, exp_bus(LAT_B, e - seg + 1, sa));
  endtask

  // Write held for "hold" cycles (the last sample carries d), then released.
  task automatic do_write(input logic [19:0] a, input logic [31:0] d, input logic [3:0] be,
                          input int hold, input bit confl, input bit drv);
    logic [31:0] last, w;
    int unsigned idx;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (i > 0) begin
        check("err_during_wr_l1", {31'd0, err1}, {31'd0, err_exp | confl});
        check("err_during_wr_l3", {31'd0, err3}, {31'd0, err_exp | confl});
        if (!drv) begin
          check("undriven_wr_l1", bus1, 32'hFFFF_FFFF);
          check("undriven_wr_l3", bus3, 32'hFFFF_FFFF);
        end
      end
      ce_n = 1'b0; we_n = 1'b0; oe_n = confl ? 1'b0 : 1'b1;
      addr = a; be_n = be; tb_drive = drv;
      tb_data = (i == hold - 1) ? d : $urandom;
    end
    last = drv ? d : 32'hFFFF_FFFF;
    @(negedge clk);
    check("err_last_wr_l1", {31'd0, err1}, {31'd0, err_exp | confl});
    if (!drv) check("undriven_last_l3", bus3, 32'hFFFF_FFFF);
    tb_drive = 1'b0; oe_n = 1'b1;
    if ($urandom_range(0, 1) == 1) ce_n = 1'b1; else we_n = 1'b1;
    @(negedge clk);
    idx = widx(a);
    if (ref_mem.exists(idx)) begin
      w = ref_mem[idx];
      for (int k = 0; k < 4; k++) if (!be[k]) w[8*k +: 8] = last[8*k +: 8];
      ref_mem[idx] = w;
    end else if (be == 4'h0) begin
      ref_mem[idx] = last;
      known.push_back(idx);
    end
    wr_exp  = sat16(wr_exp);
    err_exp = err_exp | confl;
    idle_inputs();
    check("bus_after_wr_l1", bus1, 32'hFFFF_FFFF);
    check("bus_after_wr_l3", bus3, 32'hFFFF_FFFF);
    check_status();
  endtask

  // Read a1 for n1 edges, then a2 for n2 edges (n2=0: no change). It then
  // either releases or, with then_write, leaves the read to a following write.
  task automatic do_read(input logic [19:0] a1, input int n1, input logic [19:0] a2,
                         input int n2, input bit then_write);
    int total, len;
    total = n1 + n2;
    len   = (n2 > 0) ? n2 : n1;
    for (int e = 0; e < total; e++) begin
      @(negedge clk);
      if (e > 0) check_bus(e - 1, a1, n1, a2);
      ce_n = 1'b0; oe_n = 1'b0; we_n = 1'b1; tb_drive = 1'b0;
      addr = (e < n1) ? a1 : a2;
      be_n = 4'($urandom);
    end
    if (then_write) return;
    @(negedge clk);
    check_bus(total - 1, a1, n1, a2);
    oe_n = 1'b1;
    ce_n = 1'($urandom_range(0, 1));
    @(negedge clk);
    check("bus_release_l1", bus1, 32'hFFFF_FFFF);
    check("bus_release_l3", bus3, 32'hFFFF_FFFF);
    idle_inputs();
    if (len >= LAT_A) rd_exp1 = sat16(rd_exp1);
    if (len >= LAT_B) rd_exp3 = sat16(rd_exp3);
    check_status();
  endtask

  initial begin
    idle_inputs();
    addr = 20'd0; be_n = 4'hF; tb_data = 32'd0;
    rd_exp1 = 16'd0; rd_exp3 = 16'd0; wr_exp = 16'd0; err_exp = 1'b0;

    // Reset state.
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    check("reset_bus_l1", bus1, 32'hFFFF_FFFF);
    check("reset_bus_l3", bus3, 32'hFFFF_FFFF);
    check_status();

    // Full write then read with latency.
    do_write(20'd5, 32'hDEAD_BEEF, 4'h0, 1, 1'b0, 1'b1);
    do_read(20'd5, 2, 20'd0, 0, 1'b0);
    do_read(20'd5, 4, 20'd0, 0, 1'b0);

    // Byte-lane merge.
    do_write(20'd5, 32'h1122_3344, 4'b1010, 1, 1'b0, 1'b1);
    do_read(20'd5, 3, 20'd0, 0, 1'b0);

    // Latency restart on address change mid-wait, and change while driving.
    do_write(20'd7, 32'h7777_0007, 4'h0, 2, 1'b0, 1'b1);
    do_write(20'd8, 32'h8888_0008, 4'h0, 3, 1'b0, 1'b1);
    do_write(20'd3, 32'h0000_0000, 4'h0, 1, 1'b0, 1'b1);
    do_read(20'd7, 2, 20'd8, 4, 1'b0);
    do_read(20'd7, 4, 20'd8, 4, 1'b0);
    do_read(20'd8, 1, 20'd7, 2, 1'b0);

    // All lanes disabled: counts, changes nothing.
    do_write(20'd5, 32'h0BAD_0BAD, 4'hF, 2, 1'b0, 1'b1);
    do_read(20'd5, 3, 20'd0, 0, 1'b0);

    // Upper address bits alias.
    do_write(20'hFFC05, 32'hCAFE_F00D, 4'h0, 1, 1'b0, 1'b1);
    do_read(20'h00005, 3, 20'h3FC07, 3, 1'b0);

    // Conflict: treated as a write, sticky flag.
    do_write(20'd2, 32'hA5A5_A5A5, 4'h0, 2, 1'b1, 1'b1);
    do_read(20'd2, 3, 20'd0, 0, 1'b0);
    do_write(20'd10, 32'h0, 4'h0, 3, 1'b1, 1'b0);

    // Conflict arriving while a read drives the bus abandons the read.
    do_read(20'd7, 5, 20'd0, 0, 1'b1);
    do_write(20'd9, 32'h9999_1234, 4'h0, 3, 1'b1, 1'b1);
    do_read(20'd9, 3, 20'd0, 0, 1'b0);

    // Randomized mix of writes and reads.
    for (int t = 0; t < 60; t++) begin
      if (known.size() < 2 || $urandom_range(0, 1) == 1) begin
        int unsigned w;
        logic [3:0] be;
        w  = 16 + $urandom_range(0, 15);
        be = 4'($urandom);
        if (!ref_mem.exists(w)) be = 4'h0;
        do_write(mk_addr(w), $urandom, be, $urandom_range(1, 3),
                 ($urandom_range(0, 7) == 0), 1'b1);
      end else begin
        int i1, i2, n2;
        i1 = $urandom_range(0, known.size() - 1);
        i2 = (i1 + 1 + $urandom_range(0, known.size() - 2)) % known.size();
        n2 = ($urandom_range(0, 9) < 4) ? $urandom_range(1, 5) : 0;
        do_read(mk_addr(known[i1]), $urandom_range(1, 5), mk_addr(known[i2]), n2, 1'b0);
      end
    end

    // Reset during an active write discards it and clears status.
    @(negedge clk);
    ce_n = 1'b0; we_n = 1'b0; oe_n = 1'b1; addr = 20'd3; be_n = 4'h0;
    tb_drive = 1'b1; tb_data = 32'h1234_5678;
    @(negedge clk);
    resetn = 1'b0;
    idle_inputs();
    @(negedge clk);
    resetn = 1'b1;
    rd_exp1 = 16'd0; rd_exp3 = 16'd0; wr_exp = 16'd0; err_exp = 1'b0;
    check("bus_after_reset_l1", bus1, 32'hFFFF_FFFF);
    check("bus_after_reset_l3", bus3, 32'hFFFF_FFFF);
    check_status();
    do_read(20'd3, 3, 20'd0, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
